// File: rtl/regfile_wr_if.sv
// Two-requester register-file write bus: requester A/B handshakes, hold, and the
// arbitrated write port with its pointer/mux status.
interface regfile_wr_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
);
  logic              req_a;
  logic [ADDR_W-1:0] addr_a;
  logic [DATA_W-1:0] data_a;
  logic              ack_a;
  logic              req_b;
  logic [ADDR_W-1:0] addr_b;
  logic [DATA_W-1:0] data_b;
  logic              ack_b;
  logic              hold;
  logic              mux_sel;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              last_a;

  modport master (
    output req_a, addr_a, data_a, req_b, addr_b, data_b, hold,
    input  ack_a, ack_b, mux_sel, wr_en, wr_addr, wr_data, last_a
  );

  modport slave (
    input  req_a, addr_a, data_a, req_b, addr_b, data_b, hold,
    output ack_a, ack_b, mux_sel, wr_en, wr_addr, wr_data, last_a
  );
endinterface

// File: rtl/regfile_wr_arbiter.sv
// Round-robin arbiter between two register-file writers; all outputs registered,
// one grant per edge, writes to register 0 acknowledged but suppressed.
module regfile_wr_arbiter #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  regfile_wr_if.slave  bus
);

  typedef enum logic {LAST_B = 1'b0, LAST_A = 1'b1} ptr_e;

  ptr_e              state_q, state_d;
  logic              ack_a_q, ack_a_d;
  logic              ack_b_q, ack_b_d;
  logic              wr_en_q, wr_en_d;
  logic              mux_sel_q, mux_sel_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic              elig_a, elig_b;
  logic              grant_a, grant_b;

  // A request still being acknowledged is not eligible, so it cannot win twice.
  assign elig_a = bus.req_a & ~ack_a_q;
  assign elig_b = bus.req_b & ~ack_b_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= LAST_B;
    else        state_q <= state_d;
  end

  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    state_d = state_q;
    if (!bus.hold) begin
      if (elig_a && (!elig_b || state_q == LAST_B)) grant_a = 1'b1;
      else if (elig_b)                              grant_b = 1'b1;
    end
    if (grant_a)      state_d = LAST_A;
    else if (grant_b) state_d = LAST_B;
  end

  always_comb begin
    ack_a_d   = grant_a;
    ack_b_d   = grant_b;
    wr_en_d   = 1'b0;
    mux_sel_d = mux_sel_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    if (grant_a) begin
      mux_sel_d = 1'b1;
      wr_addr_d = bus.addr_a;
      wr_data_d = bus.data_a;
      wr_en_d   = (bus.addr_a != '0);
    end else if (grant_b) begin
      mux_sel_d = 1'b0;
      wr_addr_d = bus.addr_b;
      wr_data_d = bus.data_b;
      wr_en_d   = (bus.addr_b != '0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_a_q   <= 1'b0;
      ack_b_q   <= 1'b0;
      wr_en_q   <= 1'b0;
      mux_sel_q <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      ack_a_q   <= ack_a_d;
      ack_b_q   <= ack_b_d;
      wr_en_q   <= wr_en_d;
      mux_sel_q <= mux_sel_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign bus.ack_a   = ack_a_q;
  assign bus.ack_b   = ack_b_q;
  assign bus.wr_en   = wr_en_q;
  assign bus.mux_sel = mux_sel_q;
  assign bus.wr_addr = wr_addr_q;
  assign bus.wr_data = wr_data_q;
  assign bus.last_a  = (state_q == LAST_A);

endmodule
